// File: rtl/mips16_ctrl_exec.sv
// mips16_ctrl_exec: single-cycle control decode, ALU and program-counter
// datapath for a 16-bit MIPS-like core.
//
// Ports:
//   clock        in   rising edge updates pc
//   reset        in   synchronous, active-high; forces pc to 0
//   ir[15:0]     in   instruction: op=[15:12] rs=[11:10] rt=[9:8] rd=[7:6] imm=[7:0]
//   rd1[15:0]    in   register-file data for rs (ALU operand A)
//   rd2[15:0]    in   register-file data for rt
//   pc[15:0]     out  program-counter register
//   next_pc      out  value pc takes on the next edge (ignoring reset)
//   alu_out      out  ALU result / data-memory byte address
//   zero         out  alu_out == 0
//   reg_dst, alu_src, mem_to_reg, reg_write, mem_write  out  decoded controls
//   wr[1:0]      out  write-register select
//   branch_taken out  branch condition met
module mips16_ctrl_exec (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic [15:0] rd1,
    input  logic [15:0] rd2,
    output logic [15:0] pc,
    output logic [15:0] next_pc,
    output logic [15:0] alu_out,
    output logic        zero,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_write,
    output logic [1:0]  wr,
    output logic        branch_taken
);

    logic [9:0]  ctrl;
    logic [1:0]  branch;
    logic [2:0]  aluop;
    logic [15:0] sext;
    logic [15:0] alu_b;
    logic [15:0] pc_plus;
    logic [15:0] target;
    logic [15:0] pc_d;
    logic [15:0] pc_q;

    // rs is consumed by the register file outside this block; only rt/rd
    // matter here (for wr).
    logic unused_rs;
    assign unused_rs = ^ir[11:10];

    // {reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch[1:0], aluop[2:0]}
    always_comb begin
        ctrl = 10'b0;
        case (ir[15:12])
            4'h0:    ctrl = 10'b1_0_0_1_0_00_010;  // add
            4'h1:    ctrl = 10'b1_0_0_1_0_00_110;  // sub
            4'h2:    ctrl = 10'b1_0_0_1_0_00_000;  // and
            4'h3:    ctrl = 10'b1_0_0_1_0_00_001;  // or
            4'h4:    ctrl = 10'b0_1_0_1_0_00_010;  // addi
            4'h5:    ctrl = 10'b0_1_1_1_0_00_010;  // lw
            4'h6:    ctrl = 10'b0_1_0_0_1_00_010;  // sw
            4'h7:    ctrl = 10'b1_0_0_1_0_00_111;  // slt
            4'h8:    ctrl = 10'b0_0_0_0_0_01_110;  // beq
            4'h9:    ctrl = 10'b0_0_0_0_0_10_110;  // bne
            default: ctrl = 10'b0;                 // nop
        endcase
    end

    assign {reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, aluop} = ctrl;

    assign sext  = {{8{ir[7]}}, ir[7:0]};
    assign alu_b = alu_src ? sext : rd2;
    assign wr    = reg_dst ? ir[7:6] : ir[9:8];

    always_comb begin
        alu_out = 16'h0000;
        case (aluop)
            3'b000:  alu_out = rd1 & alu_b;
            3'b001:  alu_out = rd1 | alu_b;
            3'b010:  alu_out = rd1 + alu_b;
            3'b110:  alu_out = rd1 - alu_b;
            3'b111:  alu_out = ($signed(rd1) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
            default: alu_out = 16'h0000;
        endcase
    end

    assign zero = (alu_out == 16'h0000);

    // Branch offset is in instruction units, hence the shift by one.
    assign pc_plus      = pc_q + 16'd2;
    assign target       = pc_plus + {sext[14:0], 1'b0};
    assign branch_taken = ((branch == 2'b01) & zero) | ((branch == 2'b10) & ~zero);

    always_comb begin
        pc_d = branch_taken ? target : pc_plus;
    end

    assign next_pc = pc_d;
    assign pc      = pc_q;

    always_ff @(posedge clock) begin
        if (reset) pc_q <= 16'h0000;
        else       pc_q <= pc_d;
    end

endmodule

// File: tb/tb_mips16_ctrl_exec.sv
// Self-checking bench for mips16_ctrl_exec: directed cases followed by
// randomized instructions, all compared against an instruction-level model.
module tb_mips16_ctrl_exec;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ir    = 16'h0000;
    logic [15:0] rd1   = 16'h0000;
    logic [15:0] rd2   = 16'h0000;
    logic [15:0] pc, next_pc, alu_out;
    logic        zero, reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch_taken;
    logic [1:0]  wr;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_pc = 16'h0000;
    bit          pc_known = 1'b0;

    mips16_ctrl_exec dut (
        .clock(clock), .reset(reset), .ir(ir), .rd1(rd1), .rd2(rd2),
        .pc(pc), .next_pc(next_pc), .alu_out(alu_out), .zero(zero),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_write(mem_write), .wr(wr),
        .branch_taken(branch_taken)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] alu;
        logic        zero;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  wr;
        logic        taken;
        logic [15:0] next_pc;
    } exp_t;

    // Instruction-level reference: what each opcode does, not how it is decoded.
    function automatic exp_t model(input logic [15:0] i, input logic [15:0] a,
                                   input logic [15:0] b, input logic [15:0] p);
        exp_t e;
        logic [15:0] imm;
        e   = '0;
        imm = {{8{i[7]}}, i[7:0]};
        case (i[15:12])
            4'h0: begin e.alu = a + b; e.reg_dst = 1; e.reg_write = 1; end
            4'h1: begin e.alu = a - b; e.reg_dst = 1; e.reg_write = 1; end
            4'h2: begin e.alu = a & b; e.reg_dst = 1; e.reg_write = 1; end
            4'h3: begin e.alu = a | b; e.reg_dst = 1; e.reg_write = 1; end
            4'h7: begin
                e.alu = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                e.reg_dst = 1; e.reg_write = 1;
            end
            4'h4: begin e.alu = a + imm; e.alu_src = 1; e.reg_write = 1; end
            4'h5: begin e.alu = a + imm; e.alu_src = 1; e.reg_write = 1; e.mem_to_reg = 1; end
            4'h6: begin e.alu = a + imm; e.alu_src = 1; e.mem_write = 1; end
            4'h8: begin e.alu = a - b; e.taken = (a == b); end
            4'h9: begin e.alu = a - b; e.taken = (a != b); end
            default: e.alu = a & b;  // nop still runs the AND path on rs/rt
        endcase
        e.zero    = (e.alu == 16'd0);
        e.wr      = e.reg_dst ? i[7:6] : i[9:8];
        e.next_pc = e.taken ? 16'(p + 16'd2 + 16'(imm * 2)) : 16'(p + 16'd2);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h (ir=%h rd1=%h rd2=%h)", tag, got, exp, ir, rd1, rd2);
        end
    endtask

    // Apply inputs and check every combinational output against the model.
    task automatic drive(input logic [15:0] i, input logic [15:0] a,
                         input logic [15:0] b, input logic r);
        exp_t e;
        ir = i; rd1 = a; rd2 = b; reset = r;
        #1;
        e = model(i, a, b, exp_pc);
        chk("alu_out",    alu_out,            e.alu);
        chk("zero",       16'(zero),          16'(e.zero));
        chk("reg_dst",    16'(reg_dst),       16'(e.reg_dst));
        chk("alu_src",    16'(alu_src),       16'(e.alu_src));
        chk("mem_to_reg", 16'(mem_to_reg),    16'(e.mem_to_reg));
        chk("reg_write",  16'(reg_write),     16'(e.reg_write));
        chk("mem_write",  16'(mem_write),     16'(e.mem_write));
        chk("wr",         16'(wr),            16'(e.wr));
        chk("branch_taken", 16'(branch_taken), 16'(e.taken));
        if (pc_known) chk("next_pc", next_pc, e.next_pc);
    endtask

    // Clock one edge and check the pc register.
    task automatic tick();
        exp_t e;
        logic [15:0] nxt;
        e   = model(ir, rd1, rd2, exp_pc);
        nxt = reset ? 16'h0000 : e.next_pc;
        @(posedge clock);
        #1;
        if (reset || pc_known) begin
            exp_pc   = nxt;
            pc_known = 1'b1;
            chk("pc", pc, exp_pc);
        end
    endtask

    task automatic reset_to(input int nops);
        drive(16'hF000, 16'h0, 16'h0, 1'b1);
        tick();
        for (int k = 0; k < nops; k++) begin
            drive(16'hF000, 16'h0, 16'h0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [15:0] ri, ra, rb;
        logic        rr;

        // Reset from unknown pc; held reset keeps pc at 0.
        reset_to(0);
        drive(16'h0123, 16'h1111, 16'h2222, 1'b1);
        tick();
        chk("pc_reset_held", pc, 16'h0000);

        // Advance to pc=8, then reset over a pending taken branch.
        reset_to(4);
        chk("pc_before_reset", pc, 16'h0008);
        drive(16'h8010, 16'h0007, 16'h0007, 1'b1);
        tick();
        chk("pc_reset_overrides_branch", pc, 16'h0000);

        // Release with lw.
        drive(16'h5200, 16'h0000, 16'h1234, 1'b0);
        chk("lw_wr", 16'(wr), 16'd2);
        chk("lw_mem_to_reg", 16'(mem_to_reg), 16'd1);
        tick();
        chk("pc_after_release", pc, 16'h0002);

        // slt, signed compare.
        drive(16'h76C0, 16'd5, 16'd7, 1'b0);
        chk("slt_5_7", alu_out, 16'h0001);
        chk("slt_wr", 16'(wr), 16'd3);
        drive(16'h76C0, 16'd7, 16'd5, 1'b0);
        chk("slt_7_5", alu_out, 16'h0000);
        drive(16'h76C0, 16'hFFFF, 16'd1, 1'b0);
        chk("slt_neg", alu_out, 16'h0001);
        tick();

        // sub with negative and zero results.
        drive(16'h1640, 16'd5, 16'd7, 1'b0);
        chk("sub_neg", alu_out, 16'hFFFE);
        chk("sub_wr", 16'(wr), 16'd1);
        drive(16'h1640, 16'd9, 16'd9, 1'b0);
        chk("sub_zero", 16'(zero), 16'd1);
        tick();

        // beq/bne at pc=6.
        reset_to(3);
        drive(16'h8401, 16'd0, 16'd0, 1'b0);
        chk("beq_taken_npc", next_pc, 16'h000A);
        drive(16'h8401, 16'd1, 16'd0, 1'b0);
        chk("beq_not_npc", next_pc, 16'h0008);
        drive(16'h9401, 16'd0, 16'd0, 1'b0);
        chk("bne_not_npc", next_pc, 16'h0008);
        tick();
        reset_to(3);
        drive(16'h9401, 16'd1, 16'd0, 1'b0);
        chk("bne_taken_npc", next_pc, 16'h000A);
        tick();
        chk("pc_bne_taken", pc, 16'h000A);

        // Negative branch offset from pc=0x10.
        reset_to(8);
        drive(16'h80FE, 16'h00AA, 16'h00AA, 1'b0);
        chk("beq_back_npc", next_pc, 16'h000E);
        tick();

        // Branch from 0 back to 0xFFFE, then wrap to 0 with a nop.
        reset_to(0);
        drive(16'h80FE, 16'h0003, 16'h0003, 1'b0);
        tick();
        chk("pc_fffe", pc, 16'hFFFE);
        drive(16'hF000, 16'h1234, 16'h4321, 1'b0);
        chk("nop_npc_wrap", next_pc, 16'h0000);
        chk("nop_reg_write", 16'(reg_write), 16'd0);
        tick();
        chk("pc_wrap", pc, 16'h0000);

        // sw and addi.
        drive(16'h6102, 16'd0, 16'hBEEF, 1'b0);
        chk("sw_addr", alu_out, 16'h0002);
        chk("sw_mem_write", 16'(mem_write), 16'd1);
        tick();
        drive(16'h4105, 16'd0, 16'hBEEF, 1'b0);
        chk("addi_res", alu_out, 16'h0005);
        chk("addi_wr", 16'(wr), 16'd1);
        tick();

        // Randomized instructions with occasional reset.
        for (int n = 0; n < 300; n++) begin
            ri = 16'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rr = ($urandom_range(0, 15) == 0);
            drive(ri, ra, rb, rr);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
